// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage memory responder.
package mem_access_pkg;

  // Request opcodes on mem_memrw; 2'b11 is treated as idle.
  localparam logic [1:0] MemRwIdle  = 2'b00;
  localparam logic [1:0] MemRwRead  = 2'b01;
  localparam logic [1:0] MemRwWrite = 2'b10;

  localparam logic RstEnable = 1'b1;
  localparam logic StallYes  = 1'b1;

  typedef enum logic [1:0] {
    MemStIdle   = 2'b00,
    MemStSetup  = 2'b01,
    MemStAccess = 2'b10,
    MemStDone   = 2'b11
  } mem_st_e;

  function automatic logic is_mem_op(input logic [1:0] rw);
    return (rw == MemRwRead) || (rw == MemRwWrite);
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Pipeline-side request/write-back bundle plus the asynchronous SRAM bus.
interface mem_access_if;

  logic        stall;
  logic [1:0]  mem_memrw;
  logic [15:0] mem_memaddr;
  logic [15:0] mem_memdata;
  logic [15:0] mem_wdata;
  logic [3:0]  mem_waddr;
  logic        mem_we;

  logic [15:0] wb_wdata;
  logic [3:0]  wb_waddr;
  logic        wb_we;
  logic        stallreq;

  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic        ram_ce_n;
  logic        ram_oe_n;
  logic        ram_we_n;

  // Pipeline and SRAM side (drives requests, returns read data).
  modport master (
    output stall, mem_memrw, mem_memaddr, mem_memdata, mem_wdata, mem_waddr, mem_we,
    output ram_rdata,
    input  wb_wdata, wb_waddr, wb_we, stallreq,
    input  ram_addr, ram_wdata, ram_ce_n, ram_oe_n, ram_we_n
  );

  // Memory responder side.
  modport slave (
    input  stall, mem_memrw, mem_memaddr, mem_memdata, mem_wdata, mem_waddr, mem_we,
    input  ram_rdata,
    output wb_wdata, wb_waddr, wb_we, stallreq,
    output ram_addr, ram_wdata, ram_ce_n, ram_oe_n, ram_we_n
  );

endinterface

// File: rtl/mem_access.sv
// MEM-stage responder: runs loads/stores against an async SRAM through a
// setup/strobe/done sequence and freezes the pipeline while it is busy.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned CNT_W       = 4
) (
  input logic         clk,
  input logic         rst,
  mem_access_if.slave bus
);

  mem_st_e           state_q, state_d;
  logic              op_wr_q, op_wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       rdata_q, rdata_d;
  logic [15:0]       ram_addr_q, ram_addr_d;
  logic [15:0]       ram_wdata_q, ram_wdata_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;

  // Next-state logic for the access sequencer and its registered SRAM strobes.
  always_comb begin
    state_d     = state_q;
    op_wr_d     = op_wr_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    unique case (state_q)
      MemStIdle: begin
        if (is_mem_op(bus.mem_memrw)) begin
          op_wr_d     = (bus.mem_memrw == MemRwWrite);
          ram_addr_d  = bus.mem_memaddr;
          ram_wdata_d = bus.mem_memdata;
          ce_n_d      = 1'b0;
          state_d     = MemStSetup;
        end
      end
      MemStSetup: begin
        if (op_wr_q) begin
          we_n_d = 1'b0;
        end else begin
          oe_n_d = 1'b0;
        end
        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
        state_d = MemStAccess;
      end
      MemStAccess: begin
        if (cnt_q == '0) begin
          if (!op_wr_q) begin
            rdata_d = bus.ram_rdata;
          end
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          state_d = MemStDone;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MemStDone: begin
        // Hold the result while the pipeline is stalled so it is not re-executed.
        if (bus.stall != StallYes) begin
          state_d = MemStIdle;
        end
      end
      default: state_d = MemStIdle;
    endcase
  end

  // State registers; synchronous reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q     <= MemStIdle;
      op_wr_q     <= 1'b0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_wr_q     <= op_wr_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
    end
  end

  // Stall request and write-back bundle; non-memory ops pass through untouched.
  always_comb begin
    bus.stallreq = 1'b0;
    bus.wb_wdata = bus.mem_wdata;
    bus.wb_waddr = bus.mem_waddr;
    bus.wb_we    = bus.mem_we;
    unique case (state_q)
      MemStIdle:   bus.stallreq = is_mem_op(bus.mem_memrw);
      MemStSetup:  bus.stallreq = 1'b1;
      MemStAccess: bus.stallreq = 1'b1;
      MemStDone: begin
        if (!op_wr_q) begin
          bus.wb_wdata = rdata_q;
        end
      end
      default: bus.stallreq = 1'b0;
    endcase
  end

  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.ram_ce_n  = ce_n_q;
  assign bus.ram_oe_n  = oe_n_q;
  assign bus.ram_we_n  = we_n_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, store, load, long strobe, hold, reset abort.
module tb_mem_access;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mem_access_if bus1 ();
  mem_access_if bus3 ();

  mem_access #(.WAIT_CYCLES(1), .CNT_W(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mem_access #(.WAIT_CYCLES(3), .CNT_W(4)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // SRAM model for dut1: writes on an edge with ce_n/we_n low, reads while ce_n/oe_n low.
  logic [15:0] mem1 [0:15];
  always @(posedge clk) begin
    if (!bus1.ram_ce_n && !bus1.ram_we_n) mem1[bus1.ram_addr[3:0]] <= bus1.ram_wdata;
  end
  assign bus1.ram_rdata = (!bus1.ram_ce_n && !bus1.ram_oe_n) ? mem1[bus1.ram_addr[3:0]]
                                                            : 16'hDEAD;

  // SRAM model for dut3: valid data appears only in the third strobe cycle.
  int oe_run = 0;
  always @(posedge clk) begin
    if (!bus3.ram_oe_n) oe_run <= oe_run + 1;
    else oe_run <= 0;
  end
  assign bus3.ram_rdata = (bus3.ram_ce_n || bus3.ram_oe_n) ? 16'hDEAD :
                          (oe_run == 2) ? 16'hC0DE : 16'h0BAD;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int st_cnt;
    int oe_cnt;
    for (int i = 0; i < 16; i++) mem1[i] = 16'h0000;
    rst = 1'b1;
    bus1.stall = 1'b0; bus1.mem_memrw = 2'b00; bus1.mem_memaddr = '0; bus1.mem_memdata = '0;
    bus1.mem_wdata = '0; bus1.mem_waddr = '0; bus1.mem_we = 1'b0;
    bus3.stall = 1'b0; bus3.mem_memrw = 2'b00; bus3.mem_memaddr = '0; bus3.mem_memdata = '0;
    bus3.mem_wdata = '0; bus3.mem_waddr = '0; bus3.mem_we = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_ce_n", bus1.ram_ce_n, 1);
    chk("rst_oe_n", bus1.ram_oe_n, 1);
    chk("rst_we_n", bus1.ram_we_n, 1);
    chk("rst_addr", bus1.ram_addr, 0);
    chk("rst_wdata", bus1.ram_wdata, 0);
    chk("rst_stallreq", bus1.stallreq, 0);

    // Pass-through
    bus1.mem_wdata = 16'h1234; bus1.mem_waddr = 4'd3; bus1.mem_we = 1'b1;
    #1;
    chk("pt_wdata", bus1.wb_wdata, 16'h1234);
    chk("pt_waddr", bus1.wb_waddr, 3);
    chk("pt_we", bus1.wb_we, 1);
    chk("pt_stallreq", bus1.stallreq, 0);
    chk("pt_ce_n", bus1.ram_ce_n, 1);
    bus1.mem_memrw = 2'b11;
    #1;
    chk("op11_stallreq", bus1.stallreq, 0);
    tick();
    chk("op11_ce_n", bus1.ram_ce_n, 1);

    // Store BEEF to address 2
    bus1.mem_memrw = 2'b10; bus1.mem_memaddr = 16'd2; bus1.mem_memdata = 16'hBEEF;
    bus1.mem_wdata = 16'h5555; bus1.mem_waddr = 4'd0; bus1.mem_we = 1'b0;
    #1;
    chk("st_idle_stallreq", bus1.stallreq, 1);
    chk("st_idle_ce_n", bus1.ram_ce_n, 1);
    tick();
    chk("st_setup_stallreq", bus1.stallreq, 1);
    chk("st_setup_ce_n", bus1.ram_ce_n, 0);
    chk("st_setup_we_n", bus1.ram_we_n, 1);
    chk("st_setup_addr", bus1.ram_addr, 16'd2);
    chk("st_setup_wdata", bus1.ram_wdata, 16'hBEEF);
    tick();
    chk("st_acc_stallreq", bus1.stallreq, 1);
    chk("st_acc_we_n", bus1.ram_we_n, 0);
    chk("st_acc_oe_n", bus1.ram_oe_n, 1);
    chk("st_acc_ce_n", bus1.ram_ce_n, 0);
    chk("st_acc_addr", bus1.ram_addr, 16'd2);
    tick();
    chk("st_done_stallreq", bus1.stallreq, 0);
    chk("st_done_we_n", bus1.ram_we_n, 1);
    chk("st_done_ce_n", bus1.ram_ce_n, 1);
    chk("st_done_addr", bus1.ram_addr, 16'd2);
    chk("st_done_wb", bus1.wb_wdata, 16'h5555);
    bus1.mem_memrw = 2'b00;
    tick();
    chk("st_idle2_stallreq", bus1.stallreq, 0);

    // Load from address 2 into r5
    bus1.mem_memrw = 2'b01; bus1.mem_memaddr = 16'd2; bus1.mem_wdata = 16'h0000;
    bus1.mem_waddr = 4'd5; bus1.mem_we = 1'b1;
    #1;
    chk("ld_idle_stallreq", bus1.stallreq, 1);
    tick();
    chk("ld_setup_oe_n", bus1.ram_oe_n, 1);
    chk("ld_setup_ce_n", bus1.ram_ce_n, 0);
    tick();
    chk("ld_acc_oe_n", bus1.ram_oe_n, 0);
    chk("ld_acc_we_n", bus1.ram_we_n, 1);
    tick();
    chk("ld_done_stallreq", bus1.stallreq, 0);
    chk("ld_done_oe_n", bus1.ram_oe_n, 1);
    chk("ld_done_wdata", bus1.wb_wdata, 16'hBEEF);
    chk("ld_done_waddr", bus1.wb_waddr, 5);
    chk("ld_done_we", bus1.wb_we, 1);

    // Held in DONE by an external stall
    bus1.stall = 1'b1;
    tick();
    chk("hold1_wdata", bus1.wb_wdata, 16'hBEEF);
    chk("hold1_ce_n", bus1.ram_ce_n, 1);
    chk("hold1_stallreq", bus1.stallreq, 0);
    tick();
    chk("hold2_wdata", bus1.wb_wdata, 16'hBEEF);
    chk("hold2_ce_n", bus1.ram_ce_n, 1);
    bus1.stall = 1'b0; bus1.mem_memrw = 2'b00; bus1.mem_wdata = 16'h7777;
    tick();
    chk("leave_wdata", bus1.wb_wdata, 16'h7777);
    chk("leave_ce_n", bus1.ram_ce_n, 1);
    chk("leave_stallreq", bus1.stallreq, 0);

    // Reset during ACCESS of a write
    bus1.mem_memrw = 2'b10; bus1.mem_memaddr = 16'd4; bus1.mem_memdata = 16'h1111;
    tick();
    tick();
    chk("ra_acc_we_n", bus1.ram_we_n, 0);
    rst = 1'b1; bus1.mem_memrw = 2'b00;
    tick();
    rst = 1'b0;
    chk("ra_we_n", bus1.ram_we_n, 1);
    chk("ra_ce_n", bus1.ram_ce_n, 1);
    chk("ra_addr", bus1.ram_addr, 0);
    chk("ra_stallreq", bus1.stallreq, 0);
    bus1.mem_wdata = 16'hABCD; bus1.mem_waddr = 4'd9;
    tick();
    chk("ra_pt_wdata", bus1.wb_wdata, 16'hABCD);
    chk("ra_pt_waddr", bus1.wb_waddr, 9);
    chk("ra_pt_ce_n", bus1.ram_ce_n, 1);

    // WAIT_CYCLES=3 load
    bus3.mem_memrw = 2'b01; bus3.mem_memaddr = 16'd6; bus3.mem_waddr = 4'd7; bus3.mem_we = 1'b1;
    #1;
    st_cnt = 0;
    oe_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus3.stallreq) break;
      st_cnt++;
      if (!bus3.ram_oe_n) oe_cnt++;
      tick();
    end
    chk("w3_stall_cycles", st_cnt, 5);
    chk("w3_oe_cycles", oe_cnt, 3);
    chk("w3_wdata", bus3.wb_wdata, 16'hC0DE);
    chk("w3_waddr", bus3.wb_waddr, 7);
    chk("w3_oe_n_done", bus3.ram_oe_n, 1);
    bus3.mem_memrw = 2'b00;
    tick();
    chk("w3_idle_stallreq", bus3.stallreq, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
